// File: rtl/channel_accumulator.sv
// Multi-lane windowed product accumulator: each window of KERNEL_LEN accepted
// samples is summed on top of a per-lane bias, rescaled, saturated and
// optionally rectified. The result and a one-cycle out_valid pulse appear the
// cycle after the sample that closes the window.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset
//   ena       global enable; low freezes all state
//   clr       synchronous window abort
//   in_valid  products on inData valid this cycle
//   inData    LANES signed products, 2*DATA_WIDTH each, lane 0 in the LSBs
//   inBias    LANES signed biases, DATA_WIDTH each, sampled on the first sample of a window
//   out       LANES signed results, DATA_WIDTH each
//   out_valid one-cycle pulse when out carries a new result
//   busy      high while a window is partially accumulated
module channel_accumulator #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FRAC_BITS  = 0,
  parameter int unsigned ACC_WIDTH  = 24,
  parameter int unsigned KERNEL_LEN = 9,
  parameter int unsigned LANES      = 1,
  parameter int unsigned RELU_EN    = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          ena,
  input  logic                          clr,
  input  logic                          in_valid,
  input  logic [LANES*2*DATA_WIDTH-1:0] inData,
  input  logic [LANES*DATA_WIDTH-1:0]   inBias,
  output logic [LANES*DATA_WIDTH-1:0]   out,
  output logic                          out_valid,
  output logic                          busy
);

  localparam int unsigned PW = 2 * DATA_WIDTH;
  localparam int unsigned CW = (KERNEL_LEN > 1) ? $clog2(KERNEL_LEN) : 1;
  localparam logic [CW-1:0] LAST = CW'(KERNEL_LEN - 1);

  // Saturation bounds of the DATA_WIDTH output, expressed at accumulator width
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};

  logic [CW-1:0]                  cnt_q, cnt_d;
  logic [LANES*ACC_WIDTH-1:0]     acc_q, acc_d, acc_sum;
  logic [LANES*DATA_WIDTH-1:0]    res, out_d;
  logic                           ov_d;

  // Per-lane datapath: next accumulator value and the rescaled result of it
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [PW-1:0]         prod;
    logic signed [DATA_WIDTH-1:0] bias;
    logic signed [ACC_WIDTH-1:0]  prod_ext;
    logic signed [ACC_WIDTH-1:0]  bias_ext;
    logic signed [ACC_WIDTH-1:0]  acc_cur;
    logic signed [ACC_WIDTH-1:0]  sum;
    logic signed [ACC_WIDTH-1:0]  shifted;
    logic signed [DATA_WIDTH-1:0] sat;

    assign prod     = inData[g*PW +: PW];
    assign bias     = inBias[g*DATA_WIDTH +: DATA_WIDTH];
    assign prod_ext = ACC_WIDTH'(prod);
    // Bias is aligned to the product scale (2*FRAC_BITS fractional bits)
    assign bias_ext = ACC_WIDTH'(bias) <<< FRAC_BITS;
    assign acc_cur  = acc_q[g*ACC_WIDTH +: ACC_WIDTH];
    assign sum      = (cnt_q == '0) ? (bias_ext + prod_ext) : (acc_cur + prod_ext);
    // Arithmetic shift gives floor rounding back to FRAC_BITS fractional bits
    assign shifted  = sum >>> FRAC_BITS;

    // Saturate, then rectify
    always_comb begin
      sat = shifted[DATA_WIDTH-1:0];
      if (shifted > SAT_MAX) begin
        sat = SAT_MAX[DATA_WIDTH-1:0];
      end else if (shifted < SAT_MIN) begin
        sat = SAT_MIN[DATA_WIDTH-1:0];
      end
      if ((RELU_EN != 0) && sat[DATA_WIDTH-1]) begin
        sat = '0;
      end
    end

    assign acc_sum[g*ACC_WIDTH +: ACC_WIDTH] = sum;
    assign res[g*DATA_WIDTH +: DATA_WIDTH]   = sat;
  end

  // Window sequencing: accept, abort, freeze and window completion
  always_comb begin
    cnt_d = cnt_q;
    acc_d = acc_q;
    out_d = out;
    ov_d  = 1'b0;
    if (ena) begin
      if (clr) begin
        cnt_d = '0;
      end else if (in_valid) begin
        acc_d = acc_sum;
        if (cnt_q == LAST) begin
          cnt_d = '0;
          out_d = res;
          ov_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q     <= '0;
      acc_q     <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      out       <= out_d;
      out_valid <= ov_d;
      busy      <= (cnt_d != '0);
    end
  end

endmodule

// File: tb/tb_channel_accumulator.sv
// Bench for channel_accumulator: two 2-lane KERNEL_LEN=3 instances (plain and
// rectified) checked every cycle against a window-sum model, plus a
// FRAC_BITS=4 KERNEL_LEN=1 instance checked with literal values.
module tb_channel_accumulator;

  logic        clk;
  logic        rst, ena, clr, in_valid;
  logic [31:0] in_data;
  logic [15:0] in_bias;
  logic [15:0] out_a, out_r;
  logic        ov_a, ov_r, busy_a, busy_r;

  logic        f_iv;
  logic [15:0] f_data;
  logic [7:0]  f_bias, f_out;
  logic        f_ov, f_busy;

  channel_accumulator #(.DATA_WIDTH(8), .FRAC_BITS(0), .ACC_WIDTH(24),
                        .KERNEL_LEN(3), .LANES(2), .RELU_EN(0)) u_dut (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .in_valid(in_valid),
    .inData(in_data), .inBias(in_bias), .out(out_a), .out_valid(ov_a), .busy(busy_a));

  channel_accumulator #(.DATA_WIDTH(8), .FRAC_BITS(0), .ACC_WIDTH(24),
                        .KERNEL_LEN(3), .LANES(2), .RELU_EN(1)) u_relu (
    .clk(clk), .rst(rst), .ena(ena), .clr(clr), .in_valid(in_valid),
    .inData(in_data), .inBias(in_bias), .out(out_r), .out_valid(ov_r), .busy(busy_r));

  channel_accumulator #(.DATA_WIDTH(8), .FRAC_BITS(4), .ACC_WIDTH(24),
                        .KERNEL_LEN(1), .LANES(1), .RELU_EN(0)) u_frac (
    .clk(clk), .rst(rst), .ena(1'b1), .clr(1'b0), .in_valid(f_iv),
    .inData(f_data), .inBias(f_bias), .out(f_out), .out_valid(f_ov), .busy(f_busy));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit cmp_en = 1'b0;

  // Model: samples counted in the current window and their running sum
  int     m_cnt;
  longint m_sum [2];
  int     m_out [2];
  bit     m_ov;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int lane(input logic [15:0] v, input int l);
    logic [7:0] b;
    b = v[l*8 +: 8];
    return int'($signed(b));
  endfunction

  function automatic int sat8(input longint v);
    if (v > 127) return 127;
    if (v < -128) return -128;
    return int'(v);
  endfunction

  function automatic int relu(input int v);
    return (v < 0) ? 0 : v;
  endfunction

  // Apply the clock edge's effect to the model from the inputs just sampled
  task automatic model_update();
    logic [15:0] p;
    logic [7:0]  b;
    m_ov = 1'b0;
    if (rst) begin
      m_cnt = 0;
      for (int l = 0; l < 2; l++) begin
        m_sum[l] = 0;
        m_out[l] = 0;
      end
    end else if (ena && clr) begin
      m_cnt = 0;
    end else if (ena && in_valid) begin
      for (int l = 0; l < 2; l++) begin
        p = in_data[l*16 +: 16];
        b = in_bias[l*8 +: 8];
        if (m_cnt == 0) m_sum[l] = longint'($signed(b)) + longint'($signed(p));
        else            m_sum[l] = m_sum[l] + longint'($signed(p));
      end
      m_cnt++;
      if (m_cnt == 3) begin
        m_cnt = 0;
        m_ov  = 1'b1;
        for (int l = 0; l < 2; l++) m_out[l] = sat8(m_sum[l]);
      end
    end
  endtask

  task automatic step(input bit r, input bit e, input bit c, input bit v,
                      input int p0, input int p1, input int b0, input int b1);
    rst      = r;
    ena      = e;
    clr      = c;
    in_valid = v;
    in_data  = {16'(p1), 16'(p0)};
    in_bias  = {8'(b1), 8'(b0)};
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0, 0);
  endtask

  // Every-cycle comparison of both KERNEL_LEN=3 instances against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("ov", int'(ov_a), int'(m_ov));
      chk("busy", int'(busy_a), int'(m_cnt != 0));
      chk("relu_ov", int'(ov_r), int'(m_ov));
      chk("relu_busy", int'(busy_r), int'(m_cnt != 0));
      for (int l = 0; l < 2; l++) begin
        chk($sformatf("out_lane%0d", l), lane(out_a, l), m_out[l]);
        chk($sformatf("relu_out_lane%0d", l), lane(out_r, l), relu(m_out[l]));
      end
    end
  end

  initial begin
    f_iv = 1'b0; f_data = '0; f_bias = '0;
    m_cnt = 0; m_ov = 1'b0;
    for (int l = 0; l < 2; l++) begin m_sum[l] = 0; m_out[l] = 0; end

    // Reset, even with ena/clr/in_valid active
    step(1, 1, 1, 1, 9, 9, 9, 9);
    cmp_en = 1'b1;
    step(1, 1, 0, 1, 9, 9, 9, 9);
    chk("rst_out", int'(out_a), 0);
    chk("rst_ov", int'(ov_a), 0);
    chk("rst_busy", int'(busy_a), 0);
    chk("rst_frac_out", int'(f_out), 0);
    idle(1);

    // Back-to-back window: lane0 3,7,5 bias 2; lane1 -1 x3 bias 0
    step(0, 1, 0, 1, 3, -1, 2, 0);
    chk("w1_busy_after_first", int'(busy_a), 1);
    step(0, 1, 0, 1, 7, -1, 0, 0);
    step(0, 1, 0, 1, 5, -1, 0, 0);
    chk("w1_ov", int'(ov_a), 1);
    chk("w1_lane0", lane(out_a, 0), 17);
    chk("w1_lane1", lane(out_a, 1), -3);
    chk("w1_relu_lane1", lane(out_r, 1), 0);
    idle(1);
    chk("w1_ov_drop", int'(ov_a), 0);
    chk("w1_hold", lane(out_a, 0), 17);

    // Saturation both ways, and rectification of the negative lane
    step(0, 1, 0, 1, 100, -100, 10, 0);
    step(0, 1, 0, 1, 100, -100, 0, 0);
    step(0, 1, 0, 1, 100, -100, 0, 0);
    chk("sat_hi", lane(out_a, 0), 127);
    chk("sat_lo", lane(out_a, 1), -128);
    chk("relu_sat_hi", lane(out_r, 0), 127);
    chk("relu_sat_lo", lane(out_r, 1), 0);
    idle(2);

    // Gaps and ena-low freezes inside a window
    step(0, 1, 0, 1, 3, 1, 2, 0);
    idle(1);
    step(0, 0, 0, 1, 50, 50, 50, 50);
    step(0, 0, 1, 1, 50, 50, 50, 50);
    chk("freeze_busy", int'(busy_a), 1);
    step(0, 1, 0, 1, 7, 1, 99, 99);
    idle(2);
    step(0, 1, 0, 1, 5, 1, 99, 99);
    chk("gap_ov", int'(ov_a), 1);
    chk("gap_lane0", lane(out_a, 0), 17);
    chk("gap_lane1", lane(out_a, 1), 3);
    idle(1);

    // Abort a partial window with clr while in_valid is high
    step(0, 1, 0, 1, 9, 9, 1, 1);
    step(0, 1, 0, 1, 9, 9, 0, 0);
    step(0, 1, 1, 1, 9, 9, 0, 0);
    chk("clr_busy", int'(busy_a), 0);
    chk("clr_ov", int'(ov_a), 0);
    chk("clr_hold", lane(out_a, 0), 17);
    step(0, 1, 0, 1, 3, -5, 2, -3);
    step(0, 1, 0, 1, 7, -6, 0, 0);
    step(0, 1, 0, 1, 5, -7, 0, 0);
    chk("post_clr_lane0", lane(out_a, 0), 17);
    chk("post_clr_lane1", lane(out_a, 1), -21);
    idle(1);

    // Reset mid-window
    step(0, 1, 0, 1, 4, 4, 1, 1);
    step(1, 1, 0, 1, 4, 4, 1, 1);
    chk("midrst_out", int'(out_a), 0);
    chk("midrst_busy", int'(busy_a), 0);
    step(1, 1, 0, 0, 0, 0, 0, 0);
    step(0, 1, 0, 1, 1, 2, 0, 0);
    step(0, 1, 0, 1, 1, 2, 0, 0);
    step(0, 1, 0, 1, 1, 2, 0, 0);
    chk("after_rst_lane0", lane(out_a, 0), 3);
    chk("after_rst_lane1", lane(out_a, 1), 6);
    idle(1);

    // Fixed-point, single-sample windows: 1.0 + 1.5 = 2.5, then floor(-1.5) = -2
    f_iv = 1'b1; f_data = 16'h0180; f_bias = 8'h10;
    idle(1);
    f_iv = 1'b0;
    chk("frac_ov", int'(f_ov), 1);
    chk("frac_out", int'(f_out), 8'h28);
    idle(1);
    chk("frac_ov_drop", int'(f_ov), 0);
    chk("frac_hold", int'(f_out), 8'h28);
    f_iv = 1'b1; f_data = 16'hFFE8; f_bias = 8'h00;
    idle(1);
    f_iv = 1'b0;
    chk("frac_floor", int'(f_out), 8'hFE);
    chk("frac_busy", int'(f_busy), 0);
    idle(2);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
